mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the instruction-fetch port and the data-memory port of the core onto one shared SRAM-like memory interface with a req/addr_ok/data_ok handshake. It sits between the Fetch/Memory pipeline stages and the bus bridge, and allows one outstanding transaction at a time. Each requester sees an accept pulse (ready) and a response pulse (data_ok). Pipeline flush discards an in-flight instruction response without corrupting the bus protocol.

## Interface
- DATA_FIRST, 1, when 1 data wins simultaneous requests; when 0 the last-granted requester loses (round-robin).
- RESET_LAST, 0, value of the last-granted register after reset (0 = inst, 1 = data).

- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush from CTRL; kills pending instruction response
- inst_req  in  1  fetch request; held until inst_ready
- inst_addr  in  32  fetch address
- inst_ready  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  one-cycle pulse, inst_rdata valid
- inst_rdata  out  32  fetched instruction
- data_req  in  1  load/store request; held until data_ready
- data_wr  in  1  1 = store
- data_size  in  2  0 byte, 1 half, 2 word
- data_wstrb  in  4  byte enables for stores
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_ready  out  1  data request accepted this cycle
- data_data_ok  out  1  one-cycle pulse: load data valid or store complete
- data_rdata  out  32  load data
- mem_req, mem_wr  out  1 each  shared-bus request / write
- mem_size  out  2  shared-bus size (fetch always 2)
- mem_wstrb  out  4  shared-bus byte enables (fetch always 0)
- mem_addr, mem_wdata  out  32 each  shared-bus address / write data (fetch wdata 0)
- mem_addr_ok  in  1  bus accepted the address
- mem_data_ok  in  1  bus returned data / write response
- mem_rdata  in  32  bus read data

## Operation
- FSM states: IDLE, REQ, WAIT. Registers: owner (0 inst, 1 data), last, discard, and latched copies of wr/size/wstrb/addr/wdata.
- IDLE: the grant is combinational.
  - Only data_req: grant data.
  - Only inst_req with flush=0: grant inst.
  - Both: DATA_FIRST=1 grants data; otherwise grant the requester other than last.
  - inst_req is never granted in a cycle with flush=1.
  - On a grant: pulse that port's ready, latch its fields (fetch latches wr=0, size=2, wstrb=0, wdata=0), set owner and last, go to REQ.
- REQ: mem_req=1 with latched fields, held stable until mem_addr_ok. On mem_addr_ok go to WAIT.
- WAIT: mem_req=0. On mem_data_ok go to IDLE and forward mem_rdata.
  - owner=1: data_data_ok = mem_data_ok.
  - owner=0: inst_data_ok = mem_data_ok & ~discard & ~flush.
- inst_rdata and data_rdata are driven by mem_rdata combinationally. Each is meaningful only while its data_ok is high.
- Flush while owner=0 in REQ or WAIT sets discard. The bus transaction still completes; its response is dropped. discard clears on entry to IDLE.
- Flush never affects a data transaction.
- The bus never drives mem_data_ok in the same cycle as its mem_addr_ok. mem_data_ok outside WAIT is ignored.

## Timing
- Reset: state=IDLE, owner=0, last=RESET_LAST, discard=0, all latched fields 0. All outputs 0 during and after reset until the first grant.
- Minimum transaction is 3 cycles: grant in IDLE (ready pulse), REQ with addr_ok, WAIT with data_ok.
- Next grant comes no earlier than the cycle after data_ok, so there is at least 1 IDLE cycle between transactions.
- ready is high only in IDLE. data_ok pulses only in WAIT and lasts exactly 1 cycle.
- rst asserted mid-transaction returns the block to IDLE next cycle and drops the response. The bus bridge is reset by the same rst.

## Test plan
- Single fetch: inst_req addr 0xbfc00000, addr_ok after 2 cycles, data_ok after 3 with rdata 0x24080001 -> inst_ready pulse at T0; mem_req high T1-T2 with size=2 and wstrb=0; inst_data_ok one cycle with 0x24080001.
- Simultaneous requests, DATA_FIRST=1: inst 0xbfc00004 and data store 0x80000010, wstrb 0xF, wdata 0xdeadbeef -> data served first (mem_wr=1, exact fields), then inst; inst_ready occurs only after data_data_ok.
- Round-robin, DATA_FIRST=0, both requesting continuously -> grants alternate inst/data/inst/data. No requester waits more than one transaction.
- Flush in WAIT of a fetch -> mem_data_ok arrives, inst_data_ok stays 0, FSM reaches IDLE. A new fetch 0xbfc00380 issued after flush deasserts completes normally.
- Flush during an inst-owned REQ with addr_ok delayed 4 cycles -> mem_req and mem_addr stay stable until addr_ok; the response is dropped.
- rst asserted in WAIT -> next cycle all outputs 0 and state IDLE. A late mem_data_ok produces no data_ok pulse.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the data port and the shared memory bus of mem_port_arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface mem_port_arbiter_if;
    logic        flush;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ready;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ready;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  flush,
        input  inst_req, inst_addr,
        output inst_ready, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_ready, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output flush,
        output inst_req, inst_addr,
        input  inst_ready, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_ready, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch port and the data port onto one shared req/addr_ok/data_ok
// memory bus, one outstanding transaction at a time. A flush drops the response of
// an in-flight fetch while still letting the bus transaction complete.
module mem_port_arbiter #(
    parameter bit DATA_FIRST = 1'b1,  // 1: data wins ties; 0: round-robin on last grant
    parameter bit RESET_LAST = 1'b0   // last-granted owner after reset (0 inst, 1 data)
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;      // 0 inst, 1 data
    logic        last_q, last_d;
    logic        discard_q, discard_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        inst_elig;
    logic        grant_inst;
    logic        grant_data;
    logic        resp;

    // Pick a winner while idle; a fetch is never eligible during a flush
    always_comb begin
        inst_elig  = bus.inst_req & ~bus.flush;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state_q == StIdle) begin
            if (bus.data_req && inst_elig) begin
                if (DATA_FIRST || !last_q) begin
                    grant_data = 1'b1;
                end else begin
                    grant_inst = 1'b1;
                end
            end else begin
                grant_data = bus.data_req;
                grant_inst = inst_elig;
            end
        end
    end

    // Next-state: latch the winner's fields, then walk through the bus handshake
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        discard_d = discard_q;
        wr_d      = wr_q;
        size_d    = size_q;
        wstrb_d   = wstrb_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant_data) begin
                    state_d = StReq;
                    owner_d = 1'b1;
                    last_d  = 1'b1;
                    wr_d    = bus.data_wr;
                    size_d  = bus.data_size;
                    wstrb_d = bus.data_wstrb;
                    addr_d  = bus.data_addr;
                    wdata_d = bus.data_wdata;
                end else if (grant_inst) begin
                    state_d = StReq;
                    owner_d = 1'b0;
                    last_d  = 1'b0;
                    wr_d    = 1'b0;
                    size_d  = 2'd2;
                    wstrb_d = 4'h0;
                    addr_d  = bus.inst_addr;
                    wdata_d = 32'h0;
                end
            end
            StReq: begin
                if (bus.flush && !owner_q) discard_d = 1'b1;
                if (bus.mem_addr_ok) state_d = StWait;
            end
            StWait: begin
                if (bus.flush && !owner_q) discard_d = 1'b1;
                if (bus.mem_data_ok) begin
                    state_d   = StIdle;
                    discard_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            last_q    <= RESET_LAST;
            discard_q <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            wstrb_q   <= 4'h0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            discard_q <= discard_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            wstrb_q   <= wstrb_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Outputs are forced to 0 while rst is held so nothing leaks during reset
    assign resp             = (state_q == StWait) & bus.mem_data_ok & ~rst;
    assign bus.inst_ready   = grant_inst & ~rst;
    assign bus.data_ready   = grant_data & ~rst;
    assign bus.inst_data_ok = resp & ~owner_q & ~discard_q & ~bus.flush;
    assign bus.data_data_ok = resp & owner_q;
    assign bus.inst_rdata   = rst ? 32'h0 : bus.mem_rdata;
    assign bus.data_rdata   = rst ? 32'h0 : bus.mem_rdata;
    assign bus.mem_req      = (state_q == StReq) & ~rst;
    assign bus.mem_wr       = wr_q & ~rst;
    assign bus.mem_size     = rst ? 2'd0 : size_q;
    assign bus.mem_wstrb    = rst ? 4'h0 : wstrb_q;
    assign bus.mem_addr     = rst ? 32'h0 : addr_q;
    assign bus.mem_wdata    = rst ? 32'h0 : wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (data-first and round-robin) behind a
// select mux, directed scenarios plus a randomized run against a transaction model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    bit   sel;  // 0: data-first instance, 1: round-robin instance

    logic        flush, inst_req, data_req, data_wr, mem_addr_ok, mem_data_ok;
    logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;

    logic        inst_ready, inst_data_ok, data_ready, data_data_ok, mem_req, mem_wr;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if a_if ();
    mem_port_arbiter_if b_if ();

    mem_port_arbiter #(.DATA_FIRST(1'b1), .RESET_LAST(1'b0)) u_dut_df (
        .clk(clk), .rst(rst), .bus(a_if.slave)
    );
    mem_port_arbiter #(.DATA_FIRST(1'b0), .RESET_LAST(1'b0)) u_dut_rr (
        .clk(clk), .rst(rst), .bus(b_if.slave)
    );

    assign a_if.flush       = sel ? 1'b0  : flush;
    assign a_if.inst_req    = sel ? 1'b0  : inst_req;
    assign a_if.inst_addr   = sel ? '0    : inst_addr;
    assign a_if.data_req    = sel ? 1'b0  : data_req;
    assign a_if.data_wr     = sel ? 1'b0  : data_wr;
    assign a_if.data_size   = sel ? '0    : data_size;
    assign a_if.data_wstrb  = sel ? '0    : data_wstrb;
    assign a_if.data_addr   = sel ? '0    : data_addr;
    assign a_if.data_wdata  = sel ? '0    : data_wdata;
    assign a_if.mem_addr_ok = sel ? 1'b0  : mem_addr_ok;
    assign a_if.mem_data_ok = sel ? 1'b0  : mem_data_ok;
    assign a_if.mem_rdata   = sel ? '0    : mem_rdata;
    assign b_if.flush       = sel ? flush       : 1'b0;
    assign b_if.inst_req    = sel ? inst_req    : 1'b0;
    assign b_if.inst_addr   = sel ? inst_addr   : '0;
    assign b_if.data_req    = sel ? data_req    : 1'b0;
    assign b_if.data_wr     = sel ? data_wr     : 1'b0;
    assign b_if.data_size   = sel ? data_size   : '0;
    assign b_if.data_wstrb  = sel ? data_wstrb  : '0;
    assign b_if.data_addr   = sel ? data_addr   : '0;
    assign b_if.data_wdata  = sel ? data_wdata  : '0;
    assign b_if.mem_addr_ok = sel ? mem_addr_ok : 1'b0;
    assign b_if.mem_data_ok = sel ? mem_data_ok : 1'b0;
    assign b_if.mem_rdata   = sel ? mem_rdata   : '0;

    assign inst_ready   = sel ? b_if.inst_ready   : a_if.inst_ready;
    assign inst_data_ok = sel ? b_if.inst_data_ok : a_if.inst_data_ok;
    assign inst_rdata   = sel ? b_if.inst_rdata   : a_if.inst_rdata;
    assign data_ready   = sel ? b_if.data_ready   : a_if.data_ready;
    assign data_data_ok = sel ? b_if.data_data_ok : a_if.data_data_ok;
    assign data_rdata   = sel ? b_if.data_rdata   : a_if.data_rdata;
    assign mem_req      = sel ? b_if.mem_req      : a_if.mem_req;
    assign mem_wr       = sel ? b_if.mem_wr       : a_if.mem_wr;
    assign mem_size     = sel ? b_if.mem_size     : a_if.mem_size;
    assign mem_wstrb    = sel ? b_if.mem_wstrb    : a_if.mem_wstrb;
    assign mem_addr     = sel ? b_if.mem_addr     : a_if.mem_addr;
    assign mem_wdata    = sel ? b_if.mem_wdata    : a_if.mem_wdata;

    task automatic drive_idle();
        flush = 0; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
        data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    // All outputs stay 0 while rst is held and until the first grant
    task automatic test_reset();
        logic [107:0] outs;
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            inst_req = 1; inst_addr = 32'hbfc00000; data_req = 1; data_wr = 1;
            data_wstrb = 4'hf; data_addr = 32'h80000000; data_wdata = 32'h12345678;
            mem_data_ok = 1; mem_addr_ok = 1; mem_rdata = 32'h0badf00d;
            for (int s = 0; s < 2; s++) begin
                sel = s[0];
                #1;
                outs = {inst_ready, data_ready, inst_data_ok, data_data_ok, mem_req, mem_wr,
                        mem_size, mem_wstrb, mem_addr, mem_wdata, inst_rdata[3:0]};
                tests++;
                if (outs !== '0) begin
                    fails++;
                    $display("FAIL reset_hold sel=%0d: got %h expected 0", s, outs);
                end
            end
        end
        @(negedge clk);
        drive_idle();
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                sel = s[0];
                #1;
                outs = {inst_ready, data_ready, inst_data_ok, data_data_ok, mem_req, mem_wr,
                        mem_size, mem_wstrb, mem_addr, mem_wdata, 4'h0};
                tests++;
                if (outs !== '0) begin
                    fails++;
                    $display("FAIL reset_after sel=%0d: got %h expected 0", s, outs);
                end
            end
        end
        sel = 0;
    endtask

    task automatic test_single_fetch();
        sel = 0;
        do_reset();
        @(negedge clk); inst_req = 1; inst_addr = 32'hbfc00000; #1;
        tests++;
        if ({inst_ready, data_ready, mem_req} !== 3'b100) begin
            fails++; $display("FAIL fetch_ready: got %b expected 100", {inst_ready, data_ready, mem_req});
        end
        for (int t = 1; t <= 2; t++) begin
            @(negedge clk); inst_req = 0; mem_addr_ok = (t == 2); #1;
            tests++;
            if ({mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !==
                {1'b1, 1'b0, 2'd2, 4'h0, 32'hbfc00000, 32'h0}) begin
                fails++;
                $display("FAIL fetch_req T%0d: got req=%b wr=%b size=%0d wstrb=%h addr=%h wdata=%h",
                         t, mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata);
            end
        end
        @(negedge clk); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h24080001; #1;
        tests++;
        if ({mem_req, inst_data_ok, data_data_ok, inst_rdata} !== {3'b010, 32'h24080001}) begin
            fails++;
            $display("FAIL fetch_resp: got req=%b iok=%b dok=%b rdata=%h expected 0 1 0 24080001",
                     mem_req, inst_data_ok, data_data_ok, inst_rdata);
        end
        @(negedge clk); mem_data_ok = 0; mem_rdata = 0; #1;
        tests++;
        if ({inst_data_ok, mem_req} !== 2'b00) begin
            fails++; $display("FAIL fetch_pulse_len: got %b expected 00", {inst_data_ok, mem_req});
        end
    endtask

    task automatic test_data_first();
        sel = 0;
        do_reset();
        @(negedge clk);
        inst_req = 1; inst_addr = 32'hbfc00004;
        data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'hf;
        data_addr = 32'h80000010; data_wdata = 32'hdeadbeef;
        #1;
        tests++;
        if ({inst_ready, data_ready} !== 2'b01) begin
            fails++; $display("FAIL df_grant: got %b expected 01", {inst_ready, data_ready});
        end
        @(negedge clk); data_req = 0; mem_addr_ok = 1; #1;
        tests++;
        if ({inst_ready, mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !==
            {1'b0, 1'b1, 1'b1, 2'd2, 4'hf, 32'h80000010, 32'hdeadbeef}) begin
            fails++;
            $display("FAIL df_store_fields: got ir=%b req=%b wr=%b size=%0d wstrb=%h addr=%h wdata=%h",
                     inst_ready, mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata);
        end
        @(negedge clk); mem_addr_ok = 0; mem_data_ok = 1; #1;
        tests++;
        if ({data_data_ok, inst_ready, inst_data_ok} !== 3'b100) begin
            fails++;
            $display("FAIL df_store_done: got %b expected 100", {data_data_ok, inst_ready, inst_data_ok});
        end
        @(negedge clk); mem_data_ok = 0; #1;
        tests++;
        if ({inst_ready, data_data_ok} !== 2'b10) begin
            fails++; $display("FAIL df_inst_after: got %b expected 10", {inst_ready, data_data_ok});
        end
        @(negedge clk); inst_req = 0; mem_addr_ok = 1; #1;
        tests++;
        if ({mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !==
            {1'b1, 1'b0, 2'd2, 4'h0, 32'hbfc00004, 32'h0}) begin
            fails++;
            $display("FAIL df_fetch_fields: got req=%b wr=%b addr=%h", mem_req, mem_wr, mem_addr);
        end
        @(negedge clk); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11112222; #1;
        tests++;
        if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'h11112222}) begin
            fails++;
            $display("FAIL df_fetch_resp: got iok=%b dok=%b rdata=%h expected 1 0 11112222",
                     inst_data_ok, data_data_ok, inst_rdata);
        end
        @(negedge clk); drive_idle();
    endtask

    // Both ports request continuously; grants must alternate starting with data
    task automatic test_round_robin();
        int  grants = 0;
        int  guard  = 0;
        bit  exp_data = 1;  // last resets to inst, so data goes first
        bit  in_wait = 0;
        sel = 1;
        do_reset();
        while (grants < 8 && guard < 100) begin
            @(negedge clk);
            inst_req = 1; inst_addr = 32'hbfc00000 + 32'(guard * 4);
            data_req = 1; data_addr = 32'h80000000 + 32'(guard * 4);
            mem_addr_ok = mem_req;  // registered output, stable before inputs change
            mem_data_ok = in_wait;
            #1;
            if (inst_ready || data_ready) begin
                tests++;
                if ({inst_ready, data_ready} !== {~exp_data, exp_data}) begin
                    fails++;
                    $display("FAIL rr_grant #%0d: got inst=%b data=%b expected data=%b",
                             grants, inst_ready, data_ready, exp_data);
                end
                exp_data = ~exp_data;
                grants++;
            end
            in_wait = mem_addr_ok;
            guard++;
        end
        tests++;
        if (grants < 8) begin
            fails++; $display("FAIL rr_timeout: got %0d grants expected 8", grants);
        end
        @(negedge clk); drive_idle();
        sel = 0;
    endtask

    task automatic test_flush_wait();
        sel = 0;
        do_reset();
        @(negedge clk); inst_req = 1; inst_addr = 32'hbfc00100; #1;
        tests++;
        if (inst_ready !== 1'b1) begin
            fails++; $display("FAIL fw_ready: got %b expected 1", inst_ready);
        end
        @(negedge clk); inst_req = 0; mem_addr_ok = 1;
        @(negedge clk); mem_addr_ok = 0; flush = 1; #1;
        tests++;
        if ({mem_req, inst_data_ok} !== 2'b00) begin
            fails++; $display("FAIL fw_wait: got %b expected 00", {mem_req, inst_data_ok});
        end
        @(negedge clk); flush = 0; mem_data_ok = 1; mem_rdata = 32'h55aa55aa; #1;
        tests++;
        if (inst_data_ok !== 1'b0) begin
            fails++; $display("FAIL fw_dropped: got %b expected 0", inst_data_ok);
        end
        @(negedge clk); mem_data_ok = 0; inst_req = 1; inst_addr = 32'hbfc00380; #1;
        tests++;
        if ({inst_ready, inst_data_ok} !== 2'b10) begin
            fails++; $display("FAIL fw_idle_regrant: got %b expected 10", {inst_ready, inst_data_ok});
        end
        @(negedge clk); inst_req = 0; mem_addr_ok = 1; #1;
        tests++;
        if ({mem_req, mem_addr} !== {1'b1, 32'hbfc00380}) begin
            fails++; $display("FAIL fw_new_addr: got req=%b addr=%h", mem_req, mem_addr);
        end
        @(negedge clk); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h3c1a8000; #1;
        tests++;
        if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h3c1a8000}) begin
            fails++; $display("FAIL fw_new_resp: got ok=%b rdata=%h", inst_data_ok, inst_rdata);
        end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_flush_req();
        sel = 0;
        do_reset();
        @(negedge clk); inst_req = 1; inst_addr = 32'hbfc00200;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk); inst_req = 0; flush = (t == 1); mem_addr_ok = (t == 5); #1;
            tests++;
            if ({mem_req, mem_addr, mem_size} !== {1'b1, 32'hbfc00200, 2'd2}) begin
                fails++;
                $display("FAIL fr_stable T%0d: got req=%b addr=%h size=%0d", t, mem_req, mem_addr,
                         mem_size);
            end
        end
        @(negedge clk); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h01234567; #1;
        tests++;
        if (inst_data_ok !== 1'b0) begin
            fails++; $display("FAIL fr_dropped: got %b expected 0", inst_data_ok);
        end
        @(negedge clk); mem_data_ok = 0; inst_req = 1; inst_addr = 32'hbfc00300; flush = 1; #1;
        tests++;
        if (inst_ready !== 1'b0) begin
            fails++; $display("FAIL fr_no_grant_in_flush: got %b expected 0", inst_ready);
        end
        @(negedge clk); flush = 0; #1;
        tests++;
        if (inst_ready !== 1'b1) begin
            fails++; $display("FAIL fr_grant_after_flush: got %b expected 1", inst_ready);
        end
        @(negedge clk); inst_req = 0; mem_addr_ok = 1;
        @(negedge clk); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hcafef00d; #1;
        tests++;
        if ({inst_data_ok, inst_rdata} !== {1'b1, 32'hcafef00d}) begin
            fails++; $display("FAIL fr_clean_resp: got ok=%b rdata=%h", inst_data_ok, inst_rdata);
        end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_reset_mid();
        logic [106:0] outs;
        sel = 0;
        do_reset();
        @(negedge clk); data_req = 1; data_addr = 32'h80000040;
        @(negedge clk); data_req = 0; mem_addr_ok = 1;
        @(negedge clk); mem_addr_ok = 0; rst = 1; #1;
        outs = {inst_ready, data_ready, inst_data_ok, data_data_ok, mem_req, mem_wr,
                mem_size, mem_wstrb, mem_addr, mem_wdata, 3'b0};
        tests++;
        if (outs !== '0) begin
            fails++; $display("FAIL rm_during: got %h expected 0", outs);
        end
        @(negedge clk); rst = 0; mem_data_ok = 1; mem_rdata = 32'h77777777; #1;
        outs = {inst_ready, data_ready, inst_data_ok, data_data_ok, mem_req, mem_wr,
                mem_size, mem_wstrb, mem_addr, mem_wdata, 3'b0};
        tests++;
        if (outs !== '0) begin
            fails++; $display("FAIL rm_late_resp: got %h expected 0", outs);
        end
        @(negedge clk); drive_idle();
    endtask

    // Random traffic on both ports and random bus latencies against a transaction model
    task automatic test_random(input bit which, input int cycles);
        bit          df;
        bit          busy, addr_done, discard, owner, last;
        bit          drop_i, drop_d, in_ok, g_i, g_d, e_iok, e_dok;
        logic        t_wr;
        logic [1:0]  t_size;
        logic [3:0]  t_wstrb;
        logic [31:0] t_addr, t_wdata;
        int          addr_wait, data_wait;
        df = ~which;
        busy = 0; addr_done = 0; discard = 0; owner = 0; last = 0;
        drop_i = 0; drop_d = 0; addr_wait = 0; data_wait = 0;
        t_wr = 0; t_size = 0; t_wstrb = 0; t_addr = 0; t_wdata = 0;
        sel = which;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (drop_i) inst_req = 0;
            if (drop_d) data_req = 0;
            drop_i = 0; drop_d = 0;
            if (!inst_req && $urandom_range(0, 2) == 0) begin
                inst_req = 1; inst_addr = $urandom() & 32'hffff_fffc;
            end
            if (!data_req && $urandom_range(0, 2) == 0) begin
                data_req = 1; data_wr = 1'($urandom()); data_size = 2'($urandom_range(0, 2));
                data_wstrb = 4'($urandom()); data_addr = $urandom(); data_wdata = $urandom();
            end
            flush = ($urandom_range(0, 9) == 0);
            mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = $urandom();
            if (busy && !addr_done) begin
                if (addr_wait == 0) mem_addr_ok = 1;
                else addr_wait--;
            end else if (busy) begin
                if (data_wait == 0) mem_data_ok = 1;
                else data_wait--;
            end else if ($urandom_range(0, 7) == 0) begin
                mem_data_ok = 1;  // stray response with nothing outstanding
            end
            #1;
            in_ok = inst_req && !flush;
            g_d = !busy && data_req && (!in_ok || df || !last);
            g_i = !busy && in_ok && !g_d;
            tests++;
            if ({inst_ready, data_ready} !== {g_i, g_d}) begin
                fails++;
                $display("FAIL rnd%0d_ready c=%0d: got %b%b expected %b%b", which, c, inst_ready,
                         data_ready, g_i, g_d);
            end
            tests++;
            if (mem_req !== (busy && !addr_done)) begin
                fails++;
                $display("FAIL rnd%0d_mem_req c=%0d: got %b expected %b", which, c, mem_req,
                         busy && !addr_done);
            end
            if (busy && !addr_done) begin
                tests++;
                if ({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !==
                    {t_wr, t_size, t_wstrb, t_addr, t_wdata}) begin
                    fails++;
                    $display("FAIL rnd%0d_fields c=%0d: got %b %0d %h %h %h expected %b %0d %h %h %h",
                             which, c, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
                             t_wr, t_size, t_wstrb, t_addr, t_wdata);
                end
            end
            e_iok = busy && addr_done && mem_data_ok && !owner && !discard && !flush;
            e_dok = busy && addr_done && mem_data_ok && owner;
            tests++;
            if ({inst_data_ok, data_data_ok} !== {e_iok, e_dok}) begin
                fails++;
                $display("FAIL rnd%0d_data_ok c=%0d: got %b%b expected %b%b", which, c,
                         inst_data_ok, data_data_ok, e_iok, e_dok);
            end
            if (e_iok || e_dok) begin
                tests++;
                if ((e_iok ? inst_rdata : data_rdata) !== mem_rdata) begin
                    fails++;
                    $display("FAIL rnd%0d_rdata c=%0d: got %h expected %h", which, c,
                             e_iok ? inst_rdata : data_rdata, mem_rdata);
                end
            end
            if (g_i || g_d) begin
                busy = 1; addr_done = 0; discard = 0; owner = g_d; last = g_d;
                t_wr    = g_d ? data_wr    : 1'b0;
                t_size  = g_d ? data_size  : 2'd2;
                t_wstrb = g_d ? data_wstrb : 4'h0;
                t_addr  = g_d ? data_addr  : inst_addr;
                t_wdata = g_d ? data_wdata : 32'h0;
                addr_wait = $urandom_range(0, 3);
                data_wait = $urandom_range(0, 3);
                drop_i = g_i; drop_d = g_d;
            end else if (busy) begin
                if (flush && !owner) discard = 1;
                if (!addr_done) begin
                    if (mem_addr_ok) addr_done = 1;
                end else if (mem_data_ok) begin
                    busy = 0; discard = 0;
                end
            end
        end
        @(negedge clk); drive_idle();
        sel = 0;
    endtask

    initial begin
        rst = 1;
        sel = 0;
        drive_idle();
        test_reset();
        test_single_fetch();
        test_data_first();
        test_round_robin();
        test_flush_wait();
        test_flush_req();
        test_reset_mid();
        test_random(1'b0, 1500);
        test_random(1'b1, 1500);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
